ftdi_fifo_ctrl: RTL and testbench
=================================

Name: ftdi_fifo_ctrl

Overview:
Sequencer for the FT245-style asynchronous FTDI FIFO port in the FTDI→DDR/BRAM path.
- Generates RD#/WR# strobes and the data-bus output enable.
- Drives the enable of the byte-capture register bank and owns the receive ready flag.
- Arbitrates between host→FPGA reads and FPGA→host writes on the shared bidirectional bus.
- Presents valid/ready byte streams to the downstream buffer logic.

Parameters:
DATA_W, 8, width of FTDI data bus and stream bytes
RD_PULSE, 4, clk cycles RD# held low (≥2)
WR_PULSE, 4, clk cycles WR# held low (≥1)
TURN_GAP, 2, clk cycles of idle bus between any two strobes (≥1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ftdi_rxf_n  input  1  FTDI receive data available, low-active, asynchronous
ftdi_txe_n  input  1  FTDI transmit space available, low-active, asynchronous
ftdi_d_in  input  DATA_W  FTDI bus input sample
ftdi_rd_n  output  1  read strobe
ftdi_wr_n  output  1  write strobe
ftdi_d_oe  output  1  bus output enable (1 = FPGA drives)
ftdi_d_out  output  DATA_W  bus drive value
latch_en  output  1  one-cycle capture enable for the rx byte register bank
rx_data  output  DATA_W  captured byte
rx_valid  output  1  rx byte held
rx_ready  input  1  downstream accepts rx byte
tx_data  input  DATA_W  byte to send
tx_valid  input  1  tx byte offered
tx_ready  output  1  tx byte accepted this cycle

Behaviour:
- Reset (async assert, sync deassert):
  - rd_n=1, wr_n=1, d_oe=0, d_out=0, latch_en=0, rx_data=0, rx_valid=0, tx_ready=0.
  - State IDLE, last_grant=WR (so RD wins first), synchronizer flops =1.
- rxf_n and txe_n pass through 2-flop synchronizers; all decisions use the synced values (2-cycle latency).
- States: IDLE, RD_STROBE, WR_SETUP, WR_STROBE, GAP.
- Request conditions, evaluated in IDLE only:
  - rd_req = !rxf_s & !rx_valid
  - wr_req = !txe_s & tx_valid
  - Both set: grant the opposite of last_grant (round-robin). One set: grant it. Neither: stay in IDLE.
- Read grant (IDLE→RD_STROBE):
  - rd_n=0 for exactly RD_PULSE cycles.
  - latch_en=1 in the final low cycle only.
  - rx_data updates and rx_valid=1 on the following edge, which coincides with rd_n rising.
  - Then →GAP; last_grant=RD.
- Write grant:
  - IDLE→WR_SETUP: tx_ready=1 for this single cycle, tx_data captured into d_out, d_oe=1, wr_n=1.
  - →WR_STROBE: wr_n=0 for WR_PULSE cycles, d_oe stays 1.
  - →GAP: d_oe held 1 in the first GAP cycle for hold time, 0 afterwards. last_grant=WR.
- GAP: both strobes high for TURN_GAP cycles, then →IDLE.
- rx handshake: rx_valid cleared on the edge where rx_valid & rx_ready. A new read is never granted while rx_valid=1. rx_data is stable while valid.
- tx_ready is only asserted in WR_SETUP. It never asserts while tx_valid=0.
- Flag changes:
  - rxf_n/txe_n deasserting mid-strobe does not abort the strobe; the cycle always completes.
  - txe_n deasserting between grant and WR_STROBE does not cancel the write.
- Invariants: rd_n and wr_n are never low simultaneously. d_oe=1 never overlaps rd_n=0.
- Reset mid-strobe: outputs return to reset values immediately. Any partially read byte is discarded.
- Counters: pulse/gap counters are sized $clog2(max(RD_PULSE,WR_PULSE,TURN_GAP)+1) and saturate at the terminal count.

Optional Feature:
FTDI_BYTE_CNT_EN:
- Defined: adds outputs rx_count[31:0] and tx_count[31:0].
  - Each resets to 0.
  - rx_count increments on every latch_en; tx_count on every tx_ready.
  - Both wrap 0xFFFFFFFF→0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package ftdi_ctrl_pkg:
  - state enum (IDLE, RD_STROBE, WR_SETUP, WR_STROBE, GAP)
  - grant encoding constants GRANT_RD/GRANT_WR
  - 32-bit counter width constant
- Sub-module ftdi_sync2: 2-flop synchronizer with async active-low reset to 1, instantiated for rxf_n and txe_n.

Test Plan:
- Read: rxf_n=0, d_in=0xA5, rx_ready=0 → after reset, rd_n low exactly 4 cycles; latch_en a single cycle on the 4th; rx_data=0xA5, rx_valid=1; no second rd_n until rx_ready pulsed.
- Write: tx_valid=1, tx_data=0x3C, txe_n=0 → tx_ready one cycle; d_oe=1 with d_out=0x3C one cycle before wr_n falls; wr_n low 4 cycles; d_oe drops 1 cycle after wr_n rises.
- Arbitration: rxf_n=0, txe_n=0, tx_valid=1, rx_ready=1 held → strobes alternate RD,WR,RD,WR; each pair separated by exactly 2 idle cycles; rd_n and wr_n never both low.
- Flag drop: rxf_n goes high during 2nd RD cycle → strobe still 4 cycles and byte captured; no further read while rxf_n=1.
- Reset abort: reset low during WR_STROBE cycle 2 → wr_n=1, d_oe=0 combinationally; after release, the first grant is RD when both requests are present.
- FTDI_BYTE_CNT_EN: 5 reads + 3 writes → rx_count=5, tx_count=3; preload-equivalent of 0xFFFFFFFF plus one read → rx_count=0.

Source files
------------

// File: rtl/ftdi_ctrl_pkg.sv
// Shared types and constants for the FT245-style FTDI FIFO sequencer.
package ftdi_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_STROBE,
      WR_SETUP,
      WR_STROBE,
      GAP
   } state_e;

   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

   localparam int BYTE_CNT_W = 32;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ftdi_sync2.sv
// Two-flop synchronizer for low-active FTDI status flags; resets to the
// inactive (high) level so nothing is requested while coming out of reset.
module ftdi_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/ftdi_fifo_ctrl.sv
// FT245-style FIFO port sequencer: round-robin read/write arbitration, strobe
// timing and rx/tx byte streams. Optional byte counters: FTDI_BYTE_CNT_EN.
module ftdi_fifo_ctrl
   import ftdi_ctrl_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int RD_PULSE = 4,
   parameter int WR_PULSE = 4,
   parameter int TURN_GAP = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ftdi_rxf_n,
   input  logic                  ftdi_txe_n,
   input  logic [DATA_W-1:0]     ftdi_d_in,
   output logic                  ftdi_rd_n,
   output logic                  ftdi_wr_n,
   output logic                  ftdi_d_oe,
   output logic [DATA_W-1:0]     ftdi_d_out,
   output logic                  latch_en,
   output logic [DATA_W-1:0]     rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   input  logic [DATA_W-1:0]     tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready
`ifdef FTDI_BYTE_CNT_EN
   ,
   output logic [BYTE_CNT_W-1:0] rx_count,
   output logic [BYTE_CNT_W-1:0] tx_count
`endif
);

   localparam int CNT_MAX = max3(RD_PULSE, WR_PULSE, TURN_GAP);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_PULSE - 1);
   localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_PULSE - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TURN_GAP - 1);

   logic              rxf_s;
   logic              txe_s;
   state_e            state_q,      state_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] d_out_q,      d_out_d;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q,   rx_valid_d;
   logic              rd_req;
   logic              wr_req;
   logic [CNT_W-1:0]  cnt_inc;

   ftdi_sync2 u_sync_rxf (
      .clk   (clk),
      .reset (reset),
      .d_i   (ftdi_rxf_n),
      .q_o   (rxf_s)
   );

   ftdi_sync2 u_sync_txe (
      .clk   (clk),
      .reset (reset),
      .d_i   (ftdi_txe_n),
      .q_o   (txe_s)
   );

   assign rd_req  = !rxf_s && !rx_valid_q;
   assign wr_req  = !txe_s && tx_valid;
   assign cnt_inc = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      d_out_d      = d_out_q;
      unique case (state_q)
         IDLE: begin
            if (rd_req && (!wr_req || last_grant_q == GRANT_WR)) begin
               state_d = RD_STROBE;
               cnt_d   = '0;
            end else if (wr_req) begin
               // Bus value is set up during WR_SETUP, ahead of the WR# fall.
               state_d = WR_SETUP;
               d_out_d = tx_data;
            end
         end
         RD_STROBE: begin
            if (cnt_q == RD_LAST) begin
               state_d      = GAP;
               cnt_d        = '0;
               last_grant_d = GRANT_RD;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WR_SETUP: begin
            state_d = WR_STROBE;
            cnt_d   = '0;
         end
         WR_STROBE: begin
            if (cnt_q == WR_LAST) begin
               state_d      = GAP;
               cnt_d        = '0;
               last_grant_d = GRANT_WR;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Strobes decode straight from state so an async reset releases them at once.
   assign ftdi_rd_n  = (state_q != RD_STROBE);
   assign ftdi_wr_n  = (state_q != WR_STROBE);
   assign ftdi_d_oe  = (state_q == WR_SETUP) || (state_q == WR_STROBE) ||
                       ((state_q == GAP) && (cnt_q == '0) && (last_grant_q == GRANT_WR));
   assign ftdi_d_out = d_out_q;
   assign latch_en   = (state_q == RD_STROBE) && (cnt_q == RD_LAST);
   assign tx_ready   = (state_q == WR_SETUP) && tx_valid;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;

   always_comb begin
      rx_valid_d = rx_valid_q;
      if (latch_en) begin
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= GRANT_WR;
         d_out_q      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         d_out_q      <= d_out_d;
         rx_valid_q   <= rx_valid_d;
         if (latch_en) begin
            rx_data_q <= ftdi_d_in;
         end
      end
   end

`ifdef FTDI_BYTE_CNT_EN
   logic [BYTE_CNT_W-1:0] rx_cnt_q;
   logic [BYTE_CNT_W-1:0] tx_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_cnt_q <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (latch_en) rx_cnt_q <= rx_cnt_q + BYTE_CNT_W'(1);
         if (tx_ready) tx_cnt_q <= tx_cnt_q + BYTE_CNT_W'(1);
      end
   end

   assign rx_count = rx_cnt_q;
   assign tx_count = tx_cnt_q;
`endif

endmodule

// File: tb/tb_ftdi_fifo_ctrl.sv
// Self-checking bench for ftdi_fifo_ctrl: cycle vector table plus directed
// sequences for arbitration, flag drop, reset abort and byte counters.
module tb_ftdi_fifo_ctrl;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          rxf_n, txe_n;
   logic [DW-1:0] d_in;
   logic          rd_n, wr_n, d_oe;
   logic [DW-1:0] d_out;
   logic          latch_en;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
`ifdef FTDI_BYTE_CNT_EN
   logic [31:0]   rx_count, tx_count;
`endif

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   ftdi_fifo_ctrl #(
      .DATA_W   (DW),
      .RD_PULSE (4),
      .WR_PULSE (4),
      .TURN_GAP (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ftdi_rxf_n (rxf_n),
      .ftdi_txe_n (txe_n),
      .ftdi_d_in  (d_in),
      .ftdi_rd_n  (rd_n),
      .ftdi_wr_n  (wr_n),
      .ftdi_d_oe  (d_oe),
      .ftdi_d_out (d_out),
      .latch_en   (latch_en),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
`ifdef FTDI_BYTE_CNT_EN
      ,
      .rx_count   (rx_count),
      .tx_count   (tx_count)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      rxf_n    = 1'b1;
      txe_n    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      rx_ready = 1'b0;
      d_in     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Bus-level invariants watched throughout the directed tests.
   always @(negedge clk) begin
      if (mon_en && reset) begin
         check("strobe_overlap", {63'd0, (!rd_n && !wr_n)}, 64'd0);
         check("oe_during_rd",   {63'd0, (d_oe && !rd_n)},  64'd0);
      end
   end

   // Expected bundle: {rd_n, wr_n, d_oe, latch_en, rx_valid, tx_ready, rx_data, d_out}
   typedef struct {
      bit          pre_rst;
      logic        rxf;
      logic        txe;
      logic        txv;
      logic        rdy;
      logic [7:0]  txd;
      logic [7:0]  din;
      logic [21:0] exp;
   } vec_t;

   function automatic vec_t row(input bit pre, input logic rxf, input logic txe,
                                input logic txv, input logic rdy, input logic [7:0] txd,
                                input logic [7:0] din, input logic [5:0] ctl,
                                input logic [7:0] rxd, input logic [7:0] dout);
      vec_t v;
      v.pre_rst = pre;
      v.rxf     = rxf;
      v.txe     = txe;
      v.txv     = txv;
      v.rdy     = rdy;
      v.txd     = txd;
      v.din     = din;
      v.exp     = {ctl, rxd, dout};
      return v;
   endfunction

   vec_t        vecs[$];
   logic [1:0]  smp[40];
   int          kinds[$];
   int          lens[$];
   int          idles[$];

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   n;
      int   low;
      int   idle_run;
      int   low_run;

      // ---- read: 2-cycle sync latency, 4-cycle RD#, hold until rx_ready ----
      vecs.push_back(row(1, 0, 1, 0, 0, 8'h00, 8'hA5, 6'b110000, 8'h00, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'hA5, 6'b110000, 8'h00, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'hA5, 6'b010000, 8'h00, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'hA5, 6'b010000, 8'h00, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'hA5, 6'b010000, 8'h00, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'hA5, 6'b010100, 8'h00, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'hA5, 6'b110010, 8'hA5, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'h3C, 6'b110010, 8'hA5, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'h3C, 6'b110010, 8'hA5, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'h3C, 6'b110010, 8'hA5, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 1, 8'h00, 8'h3C, 6'b110000, 8'hA5, 8'h00));
      vecs.push_back(row(0, 0, 1, 0, 0, 8'h00, 8'h3C, 6'b010000, 8'hA5, 8'h00));
      // ---- write: setup cycle with tx_ready, 4-cycle WR#, one hold cycle of d_oe ----
      vecs.push_back(row(1, 1, 0, 1, 0, 8'h3C, 8'h00, 6'b110000, 8'h00, 8'h00));
      vecs.push_back(row(0, 1, 0, 1, 0, 8'h3C, 8'h00, 6'b110000, 8'h00, 8'h00));
      vecs.push_back(row(0, 1, 0, 1, 0, 8'h3C, 8'h00, 6'b111001, 8'h00, 8'h3C));
      vecs.push_back(row(0, 1, 0, 1, 0, 8'h3C, 8'h00, 6'b101000, 8'h00, 8'h3C));
      vecs.push_back(row(0, 1, 0, 0, 0, 8'h99, 8'h00, 6'b101000, 8'h00, 8'h3C));
      vecs.push_back(row(0, 1, 0, 0, 0, 8'h99, 8'h00, 6'b101000, 8'h00, 8'h3C));
      vecs.push_back(row(0, 1, 0, 0, 0, 8'h99, 8'h00, 6'b101000, 8'h00, 8'h3C));
      vecs.push_back(row(0, 1, 0, 0, 0, 8'h99, 8'h00, 6'b111000, 8'h00, 8'h3C));
      vecs.push_back(row(0, 1, 0, 0, 0, 8'h99, 8'h00, 6'b110000, 8'h00, 8'h3C));
      vecs.push_back(row(0, 1, 0, 0, 0, 8'h99, 8'h00, 6'b110000, 8'h00, 8'h3C));

      do_reset();
      #1;
      check("reset_state", {42'd0, rd_n, wr_n, d_oe, latch_en, rx_valid, tx_ready, rx_data, d_out},
            {42'd0, 6'b110000, 8'h00, 8'h00});

      mon_en = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (v.pre_rst) do_reset();
         rxf_n    = v.rxf;
         txe_n    = v.txe;
         tx_valid = v.txv;
         rx_ready = v.rdy;
         tx_data  = v.txd;
         d_in     = v.din;
         step();
         check($sformatf("vec%0d", i),
               {42'd0, rd_n, wr_n, d_oe, latch_en, rx_valid, tx_ready, rx_data, d_out},
               {42'd0, v.exp});
      end

      // ---- arbitration: both requests held, expect RD,WR,RD,WR ----
      do_reset();
      rxf_n = 1'b0; txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h42; rx_ready = 1'b1; d_in = 8'h11;
      for (int i = 0; i < 40; i++) begin
         step();
         smp[i] = {rd_n, wr_n};
      end
      idle_run = 0;
      low_run  = 0;
      for (int i = 0; i < 40; i++) begin
         if (smp[i] == 2'b11) begin
            if (low_run > 0) begin
               lens.push_back(low_run);
               low_run = 0;
            end
            idle_run++;
         end else begin
            if (low_run == 0) begin
               kinds.push_back((smp[i] == 2'b01) ? 0 : 1);
               idles.push_back(idle_run);
               idle_run = 0;
            end
            low_run++;
         end
      end
      check("arb_enough_strobes", {63'd0, (kinds.size() >= 4 && lens.size() >= 4)}, 64'd1);
      if (kinds.size() >= 4 && lens.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_kind%0d", i), 64'(kinds[i]), 64'(i % 2));
            check($sformatf("arb_len%0d", i),  64'(lens[i]),  64'd4);
         end
         // After RD: 2 gap + 1 idle + 1 write setup; after WR: 2 gap + 1 idle.
         check("arb_idle_rd_wr", 64'(idles[1]), 64'd4);
         check("arb_idle_wr_rd", 64'(idles[2]), 64'd3);
         check("arb_idle_rd_wr2", 64'(idles[3]), 64'd4);
      end

      // ---- flag drop mid-read ----
      do_reset();
      rxf_n = 1'b0; d_in = 8'h5A;
      n = 0;
      while (rd_n && n < 20) begin
         step();
         n++;
      end
      check("fd_rd_start", {63'd0, rd_n}, 64'd0);
      step();
      rxf_n = 1'b1;
      low = 2;
      n = 0;
      while (n < 20) begin
         step();
         n++;
         if (!rd_n) low++;
         else break;
      end
      check("fd_rd_len", 64'(low), 64'd4);
      check("fd_rx_captured", {55'd0, rx_valid, rx_data}, {55'd0, 1'b1, 8'h5A});
      d_in = 8'h00;
      step();
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      check("fd_rx_cleared", {63'd0, rx_valid}, 64'd0);
      low = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!rd_n) low++;
      end
      check("fd_no_more_reads", 64'(low), 64'd0);

      // ---- reset during the second WR# low cycle ----
      do_reset();
      txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h77;
      n = 0;
      while (wr_n && n < 20) begin
         step();
         n++;
      end
      check("ra_wr_start", {63'd0, wr_n}, 64'd0);
      step();
      check("ra_wr_cycle2", {62'd0, wr_n, d_oe}, {62'd0, 2'b01});
      #2;
      reset = 1'b0;
      #1;
      check("ra_async_outputs", {51'd0, rd_n, wr_n, d_oe, tx_ready, latch_en, d_out},
            {51'd0, 5'b11000, 8'h00});
      rxf_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      while (rd_n && wr_n && n < 20) begin
         step();
         n++;
      end
      check("ra_first_grant_rd", {62'd0, rd_n, wr_n}, {62'd0, 2'b01});

`ifdef FTDI_BYTE_CNT_EN
      // ---- byte counters: 5 reads then 3 writes ----
      do_reset();
      rxf_n = 1'b0; d_in = 8'hC3;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (!rx_valid && n < 50) begin
            step();
            n++;
         end
         check($sformatf("cnt_read%0d", k), {63'd0, rx_valid}, 64'd1);
         if (k == 4) rxf_n = 1'b1;
         repeat (3) step();
         rx_ready = 1'b1;
         step();
         rx_ready = 1'b0;
      end
      txe_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tx_valid = 1'b1;
         tx_data  = 8'(k + 1);
         n = 0;
         while (!tx_ready && n < 50) begin
            step();
            n++;
         end
         check($sformatf("cnt_write%0d", k), {63'd0, tx_ready}, 64'd1);
         step();
         tx_valid = 1'b0;
         repeat (12) step();
      end
      check("cnt_rx_count", {32'd0, rx_count}, 64'd5);
      check("cnt_tx_count", {32'd0, tx_count}, 64'd3);
`endif

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
